// File: rtl/bram_port_arbiter_if.sv
// Request/response bundle between the two pipeline clients and the BRAM port arbiter.
// master = client side, slave = arbiter side.
interface bram_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  req0_valid;
    logic                  req0_we;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req0_ready;
    logic                  rsp0_valid;
    logic [DATA_WIDTH-1:0] rsp0_data;

    logic                  req1_valid;
    logic                  req1_we;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  req1_ready;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp1_data;

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req0_ready, rsp0_valid, rsp0_data,
        input  req1_ready, rsp1_valid, rsp1_data
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req0_ready, rsp0_valid, rsp0_data,
        output req1_ready, rsp1_valid, rsp1_data
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Two-port arbiter/sequencer for one single-port write-first BRAM; responses return after READ_LATENCY.
// Optional BRAM_ARB_ROUND_ROBIN_EN: alternate on contention instead of fixed port-0 priority.
//   state   | meaning
//   LAST_P0 | port 0 granted last, port 1 wins next contention
//   LAST_P1 | port 1 granted last (reset), port 0 wins next contention
module bram_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  stall,
    bram_port_arbiter_if.slave    bus,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic                  ram_rsta,
    output logic                  ram_regcea,
    input  logic [DATA_WIDTH-1:0] ram_douta
);

    generate
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $error("bram_port_arbiter: READ_LATENCY must be 1 or 2");
        end
    endgenerate

    logic grant0;
    logic grant1;
    logic prio0;

`ifdef BRAM_ARB_ROUND_ROBIN_EN
    typedef enum logic {LAST_P0 = 1'b0, LAST_P1 = 1'b1} last_t;
    last_t last_q;
    last_t last_d;

    always_ff @(posedge clka) begin
        if (rsta) begin
            last_q <= LAST_P1;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        last_d = last_q;
        if (grant0) begin
            last_d = LAST_P0;
        end else if (grant1) begin
            last_d = LAST_P1;
        end
    end

    assign prio0 = (last_q == LAST_P1);
`else
    assign prio0 = 1'b1;
`endif

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rsta && !stall) begin
            if (bus.req0_valid && (!bus.req1_valid || prio0)) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    always_comb begin
        ram_ena   = grant0 | grant1;
        ram_wea   = 1'b0;
        ram_addra = '0;
        ram_dina  = '0;
        if (grant0) begin
            ram_wea   = bus.req0_we;
            ram_addra = bus.req0_addr;
            ram_dina  = bus.req0_wdata;
        end else if (grant1) begin
            ram_wea   = bus.req1_we;
            ram_addra = bus.req1_addr;
            ram_dina  = bus.req1_wdata;
        end
    end

    // In-flight tracker: stage i holds the access issued i+1 cycles ago; never frozen by stall.
    logic [READ_LATENCY-1:0] pipe_v;
    logic [READ_LATENCY-1:0] pipe_own;

    always_ff @(posedge clka) begin
        if (rsta) begin
            pipe_v   <= '0;
            pipe_own <= '0;
        end else begin
            pipe_v[0]   <= grant0 | grant1;
            pipe_own[0] <= grant1;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_own[i] <= pipe_own[i-1];
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_regce
            assign ram_regcea = pipe_v[0] & ~rsta;
        end else begin : g_no_regce
            assign ram_regcea = 1'b1;
        end
    endgenerate

    assign ram_rsta       = rsta;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    // Gated by rsta so in-flight accesses dropped by reset never surface.
    assign bus.rsp0_valid = pipe_v[READ_LATENCY-1] & ~pipe_own[READ_LATENCY-1] & ~rsta;
    assign bus.rsp1_valid = pipe_v[READ_LATENCY-1] &  pipe_own[READ_LATENCY-1] & ~rsta;
    assign bus.rsp0_data  = ram_douta;
    assign bus.rsp1_data  = ram_douta;

endmodule
